apb_mem_slave: RTL and testbench

Parametrised APB memory-mapped slave: a second-generation completer with configurable data width, memory depth and wait states, byte-lane write strobes, alignment and range error reporting, and clean abort handling. It sits behind the APB bridge/interconnect as a generic scratch-RAM peripheral and serves as the template for future register-bank slaves.

---
 rtl/apb_pkg.sv | 27 ++
 rtl/apb_mem_slave_if.sv | 25 ++
 rtl/apb_mem_array.sv | 35 +++
 rtl/apb_mem_slave.sv | 114 +++++++++++
 tb/tb_apb_mem_slave.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared types and address-decode helpers for the APB memory slave.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } apb_slv_state_e;

  // Number of byte-offset bits below the word index (LB).
  function automatic int unsigned apb_lb(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // Flags an access that is either misaligned or past the last word.
  // The address is widened to 64 bits, so ADDR_W is limited to 64.
  function automatic logic apb_addr_err(input logic [63:0] paddr,
                                        input int unsigned data_w,
                                        input int unsigned depth);
    logic [63:0] mask;
    logic [63:0] idx;
    mask = (64'd1 << apb_lb(data_w)) - 64'd1;
    idx  = paddr >> apb_lb(data_w);
    return ((paddr & mask) != 64'd0) || (idx >= 64'(depth));
  endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB bus bundle between a requester (master) and this completer (slave).
interface apb_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [DATA_W-1:0]     pwdata;
  logic [DATA_W/8-1:0]   pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W scratch storage: byte-lane writes, clear-all reset,
// combinational read of the same word the write port addresses.
module apb_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [DATA_W/8-1:0]        wbe,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear every word on reset, otherwise merge the enabled byte lanes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/apb_mem_slave.sv
// APB scratch-RAM completer: programmable wait states, byte strobes,
// misaligned/out-of-range error response, abort on early psel drop.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic             pclk,
  input  logic             prst,
  apb_mem_slave_if.slave   bus
);
  localparam int         LB        = apb_lb(DATA_W);
  localparam int         IW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  apb_slv_state_e    state;
  apb_slv_state_e    state_next;
  logic [3:0]        wait_cnt;
  logic [3:0]        cnt_next;
  logic              do_access;
  logic              addr_err;
  logic              mem_we;
  logic [IW-1:0]     word_idx;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] resp_data;
  logic              resp_ready;
  logic              resp_err;

  assign word_idx = bus.paddr[LB +: IW];
  assign addr_err = apb_addr_err(64'(bus.paddr), DATA_W, DEPTH);
  assign mem_we   = do_access && bus.pwrite && !addr_err;

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (pclk),
    .rst   (prst),
    .we    (mem_we),
    .wbe   (bus.pstrb),
    .addr  (word_idx),
    .wdata (bus.pwdata),
    .rdata (mem_rdata)
  );

  // State register and wait-state counter.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= cnt_next;
    end
  end

  // Next-state decode; do_access marks the edge that commits the transfer.
  always_comb begin
    state_next = state;
    cnt_next   = wait_cnt;
    do_access  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.psel && bus.penable) begin
          state_next = ST_WAIT;
          cnt_next   = WAIT_INIT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!bus.psel) begin
          state_next = ST_IDLE;
        end else if (wait_cnt == 4'd0) begin
          do_access  = 1'b1;
          state_next = ST_RESP;
        end else begin
          cnt_next = wait_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Response registers: one-cycle pready pulse; data only for clean reads.
  always_ff @(posedge pclk) begin
    if (prst) begin
      resp_ready <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end else if (do_access) begin
      resp_ready <= 1'b1;
      resp_err   <= addr_err;
      resp_data  <= (addr_err || bus.pwrite) ? '0 : mem_rdata;
    end else begin
      resp_ready <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end
  end

  assign bus.prdata  = resp_data;
  assign bus.pready  = resp_ready;
  assign bus.pslverr = resp_err;
endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed + randomized bench for apb_mem_slave with two instances:
// one with zero wait states, one with three.
module tb_apb_mem_slave;
  logic        clk;
  logic        prst;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  bit          use3;

  int total;
  int bad;

  logic [31:0] m0 [32];
  logic [31:0] m3 [32];

  apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
  apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

  assign if0.psel    = psel && !use3;
  assign if0.penable = penable;
  assign if0.pwrite  = pwrite;
  assign if0.paddr   = paddr;
  assign if0.pwdata  = pwdata;
  assign if0.pstrb   = pstrb;
  assign if3.psel    = psel && use3;
  assign if3.penable = penable;
  assign if3.pwrite  = pwrite;
  assign if3.paddr   = paddr;
  assign if3.pwdata  = pwdata;
  assign if3.pstrb   = pstrb;

  logic        obs_ready;
  logic        obs_err;
  logic [31:0] obs_rdata;
  assign obs_ready = use3 ? if3.pready  : if0.pready;
  assign obs_err   = use3 ? if3.pslverr : if0.pslverr;
  assign obs_rdata = use3 ? if3.prdata  : if0.prdata;

  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_CYCLES(0)) dut0 (
    .pclk (clk), .prst (prst), .bus (if0.slave)
  );
  apb_mem_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(32), .WAIT_CYCLES(3)) dut3 (
    .pclk (clk), .prst (prst), .bus (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m0[i] = 32'd0;
      m3[i] = 32'd0;
    end
  endtask

  // One APB transfer starting with a setup cycle in the current cycle.
  task automatic xfer(input bit d3, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rd, output logic err, output int lat);
    use3 = d3; psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0;
    while (!obs_ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd  = obs_rdata;
    err = obs_err;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    chk("pready_one_cycle", {31'd0, obs_ready}, 32'd0);
  endtask

  // Transfer checked against the array model; returns the read data.
  task automatic do_op(input bit d3, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb,
                       input string tag, output logic [31:0] rd);
    logic        e_err;
    logic [31:0] e_word;
    logic        err;
    int          lat;
    int          idx;
    e_err  = (addr % 4 != 0) || (addr / 4 >= 32);
    idx    = int'(addr / 4);
    e_word = 32'd0;
    if (!e_err) e_word = d3 ? m3[idx] : m0[idx];
    xfer(d3, wr, addr, data, strb, rd, err, lat);
    chk({tag, "_lat"}, 32'(lat), d3 ? 32'd5 : 32'd2);
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
    if (!wr || e_err) begin
      chk({tag, "_rdata"}, rd, e_err ? 32'd0 : e_word);
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) e_word[b*8 +: 8] = data[b*8 +: 8];
      end
      if (d3) m3[idx] = e_word;
      else    m0[idx] = e_word;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    total = 0; bad = 0;
    use3 = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0; pstrb = 4'd0;
    model_clear();

    // reset and idle
    prst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready0", {31'd0, if0.pready}, 32'd0);
    chk("rst_pslverr0", {31'd0, if0.pslverr}, 32'd0);
    chk("rst_prdata0", if0.prdata, 32'd0);
    chk("rst_pready3", {31'd0, if3.pready}, 32'd0);
    prst = 1'b0;
    @(posedge clk); #1;
    do_op(1'b0, 1'b0, 32'h14, 32'd0, 4'h0, "rd_word5", rd);
    chk("rd_word5_zero", rd, 32'h0000_0000);

    // basic write/read and strobes
    do_op(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "wr_10", rd);
    do_op(1'b0, 1'b0, 32'h10, 32'd0, 4'h0, "rd_10", rd);
    chk("rd_10_const", rd, 32'hDEAD_BEEF);
    do_op(1'b0, 1'b1, 32'h10, 32'h1122_3344, 4'b0101, "wr_strb", rd);
    do_op(1'b0, 1'b0, 32'h10, 32'd0, 4'h0, "rd_strb", rd);
    chk("rd_strb_const", rd, 32'hDE22_BE44);
    do_op(1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'h0, "wr_nostrb", rd);
    do_op(1'b0, 1'b0, 32'h10, 32'd0, 4'h0, "rd_nostrb", rd);

    // errors; 0x82 and 0x80 alias word 0 in the low index bits
    do_op(1'b0, 1'b1, 32'h00, 32'hCAFE_F00D, 4'hF, "wr_0", rd);
    do_op(1'b0, 1'b1, 32'h82, 32'h1234_5678, 4'hF, "wr_misal", rd);
    do_op(1'b0, 1'b0, 32'h80, 32'd0, 4'h0, "rd_oor", rd);
    do_op(1'b0, 1'b1, 32'h80, 32'h1234_5678, 4'hF, "wr_oor", rd);
    do_op(1'b0, 1'b0, 32'h03, 32'd0, 4'h0, "rd_misal", rd);
    do_op(1'b0, 1'b0, 32'h00, 32'd0, 4'h0, "rd_0", rd);
    chk("rd_0_const", rd, 32'hCAFE_F00D);

    // wait states and abort
    do_op(1'b1, 1'b1, 32'h04, 32'h0BAD_CAFE, 4'hF, "w3_wr_04", rd);
    do_op(1'b1, 1'b0, 32'h04, 32'd0, 4'h0, "w3_rd_04", rd);
    use3 = 1'b1; psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h7777_7777; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    psel = 1'b0; penable = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (if3.pready) seen = 1'b1;
      end
      chk("abort_no_pready", {31'd0, seen}, 32'd0);
    end
    do_op(1'b1, 1'b0, 32'h04, 32'd0, 4'h0, "abort_rd_04", rd);
    chk("abort_rd_const", rd, 32'h0BAD_CAFE);

    // randomized traffic on both instances
    for (int n = 0; n < 80; n++) begin
      a = 32'($urandom_range(0, 35)) * 32'd4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
            32'($urandom), 4'($urandom_range(0, 15)), "rand", rd);
    end

    // reset during the wait phase of a write
    do_op(1'b1, 1'b1, 32'h08, 32'h5A5A_5A5A, 4'hF, "pre_rst_wr", rd);
    use3 = 1'b1; psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 32'h08; pwdata = 32'hA5A5_A5A5; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    prst = 1'b1; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("midrst_pready", {31'd0, if3.pready}, 32'd0);
    chk("midrst_pslverr", {31'd0, if3.pslverr}, 32'd0);
    chk("midrst_prdata", if3.prdata, 32'd0);
    prst = 1'b0;
    model_clear();
    @(posedge clk); #1;
    do_op(1'b1, 1'b0, 32'h08, 32'd0, 4'h0, "postrst_rd_08", rd);
    chk("postrst_08_zero", rd, 32'h0000_0000);
    do_op(1'b0, 1'b0, 32'h00, 32'd0, 4'h0, "postrst_rd_00", rd);
    chk("postrst_00_zero", rd, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
